cdr_lock_ctrl: RTL and testbench
================================

// Module: cdr_lock_ctrl
// PURPOSE
//  Sequences CDR bring-up: measures samples-per-symbol (nb_P) from preamble edges, then programs and starts counter_decision.
//  Afterwards it checks edge phase against the decision strobe, declares lock, and detects loss of lock.
//  Sits between the edge detector and counter_decision in the rx CDR path.
// PARAMETERS
//  NBP_W      6   width of nb_P and of the interval/phase counters
//  NBP_MIN    4   intervals shorter than this are glitches and are ignored
//  MEAS_EDGES 8   accepted intervals required before nb_P is committed
//  TIMEOUT    63  cycles without an edge in WAIT_EDGE/MEASURE before a retry
//  PH_TOL     2   allowed |phase - nb_P/2| for a good edge
//  LOCK_CNT   16  consecutive good edges needed to assert lock
//  MISS_MAX   4   consecutive bad/missing edges in LOCKED that cause loss of lock
// PORTS
//  i_clk        in   1      clock
//  i_rst        in   1      synchronous reset, active-high
//  i_start      in   1      pulse: begin acquisition (ignored unless IDLE)
//  i_stop       in   1      level: force IDLE
//  i_edge       in   1      one-cycle pulse per detected data transition
//  i_dec        in   1      decision strobe from counter_decision o_en
//  o_cdr_run    out  1      drives counter_decision i_rst (1=run, 0=clear)
//  o_nb_p       out  NBP_W  committed samples-per-symbol to counter_decision i_nb_P
//  o_locked     out  1      CDR locked
//  o_err        out  1      one-cycle pulse on timeout or loss of lock
//  o_state      out  3      current FSM state (debug)
//  o_loss_cnt   out  8      saturating loss-of-lock count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, o_cdr_run=0, o_nb_p=0, o_locked=0, o_err=0, o_loss_cnt=0, all counters 0.
//  Priority: i_rst > i_stop > FSM. i_stop clears run/locked next cycle; o_nb_p holds its value.
//  IDLE: run=0. i_start -> WAIT_EDGE.
//  WAIT_EDGE: first i_edge clears ivl_cnt and moves to MEASURE.
//   TIMEOUT cycles with no edge -> o_err pulse, stay in WAIT_EDGE (counter restarts).
//  MEASURE: ivl_cnt increments every cycle and saturates at 2^NBP_W-1.
//   On i_edge: if ivl_cnt+1 >= NBP_MIN, accept it and min_ivl = min(min_ivl, ivl_cnt+1). Reject otherwise.
//   ivl_cnt clears on every edge, including rejected ones.
//   On the MEAS_EDGES-th accepted interval: o_nb_p <= min_ivl (including that edge's interval) -> TRACK, o_cdr_run=1 next cycle.
//   Timeout (as in WAIT_EDGE) -> o_err, back to WAIT_EDGE with min_ivl reset to all-ones.
//  TRACK / LOCKED: ph_cnt clears on i_dec and otherwise increments, saturating.
//   On i_edge: phase = ph_cnt. Edge is good if |phase - (o_nb_p>>1)| <= PH_TOL.
//   i_edge coincident with i_dec: phase=0, the edge is bad, and ph_cnt still clears.
//   TRACK: good edge increments good_cnt; bad edge clears it. good_cnt==LOCK_CNT -> LOCKED, o_locked=1 next cycle.
//   LOCKED: a bad edge, or 3 consecutive i_dec with no edge, increments miss_cnt. A good edge clears it.
//   miss_cnt==MISS_MAX -> loss of lock. In the same cycle: o_locked=0, o_err pulse, o_cdr_run=0 for exactly 1 cycle,
//    then WAIT_EDGE with all counters cleared. o_nb_p holds until re-measured.
//  o_cdr_run is registered; counter_decision sees the new run state one cycle after the transition.
// CONFIGURATION
//  CDR_LOCK_CTRL_STATS_EN defined: o_loss_cnt increments on each loss of lock and saturates at 255. Reset only by i_rst.
//  Not defined: o_loss_cnt is tied to 0, the port is kept, and no counter flops are inferred.
// STRUCTURE
//  cdr_pkg: cdr_state_e {IDLE, WAIT_EDGE, MEASURE, TRACK, LOCKED} (3 bits), NBP_W default, shared saturating-increment function.
//  Sub-module cdr_interval_meas: ivl_cnt, glitch reject, min tracking, accepted-edge count and timeout.
//   Outputs: done, min_ivl, timeout. The FSM and phase check stay in cdr_lock_ctrl.
// TESTING
//  1. Reset, i_start, edges every 16 cycles x9 -> o_nb_p=16 and o_cdr_run=1 one cycle after the 9th edge; o_locked=0.
//  2. Intervals {32,16,48,16,...} with one 2-cycle glitch -> glitch rejected, o_nb_p=16.
//  3. After (1), edges at phase 8 relative to i_dec (with ±2 jitter) x16 -> o_locked=1. A phase-3 edge in TRACK resets the good count.
//  4. LOCKED, edges stop -> o_err and o_locked=0 after 4 misses (12 i_dec). o_cdr_run low exactly 1 cycle, then WAIT_EDGE.
//  5. i_start, no edges for 63 cycles -> o_err pulse, state stays WAIT_EDGE. i_stop mid-MEASURE -> IDLE next cycle.
//  6. STATS_EN: 3 forced losses -> o_loss_cnt=3. Without the macro -> 0. i_rst in LOCKED -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared types and helpers for the CDR lock controller.
package cdr_pkg;

  localparam int NBP_W_DEF = 6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_EDGE = 3'd1,
    MEASURE   = 3'd2,
    TRACK     = 3'd3,
    LOCKED    = 3'd4
  } cdr_state_e;

  // Increment that sticks at max_v; callers zero-extend narrower counters.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max_v);
    return (v >= max_v) ? max_v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cdr_interval_meas.sv
// Preamble interval measurement: glitch reject, minimum tracking, accepted-edge count, no-edge timeout.
// done/min_ivl/timeout are combinational on the edge cycle; no backpressure, edges are never stalled.
module cdr_interval_meas
  import cdr_pkg::*;
#(
  parameter int NBP_W      = NBP_W_DEF,
  parameter int NBP_MIN    = 4,
  parameter int MEAS_EDGES = 8,
  parameter int TIMEOUT    = 63
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wait,
  input  logic             i_meas,
  input  logic             i_edge,
  output logic             o_done,
  output logic             o_timeout,
  output logic [NBP_W-1:0] o_min_ivl
);

  localparam logic [7:0] IVL_MAX  = 8'((1 << NBP_W) - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] ACC_LAST = 8'(MEAS_EDGES - 1);

  logic [NBP_W-1:0] ivl_cnt_q, ivl_cnt_d, min_ivl_q, min_ivl_d, ivl_len;
  logic [7:0]       acc_cnt_q, acc_cnt_d, to_cnt_q, to_cnt_d, ivl_inc;
  logic             accept;

  always_comb begin
    ivl_inc   = sat_inc(8'(ivl_cnt_q), IVL_MAX);
    ivl_len   = ivl_inc[NBP_W-1:0];
    accept    = i_meas && i_edge && (ivl_inc >= 8'(NBP_MIN));
    ivl_cnt_d = '0;
    min_ivl_d = '1;
    acc_cnt_d = '0;
    to_cnt_d  = '0;
    o_done    = 1'b0;
    o_timeout = 1'b0;
    if (i_meas) begin
      // Every edge restarts the interval, even one rejected as a glitch.
      ivl_cnt_d = i_edge ? '0 : ivl_len;
      min_ivl_d = min_ivl_q;
      acc_cnt_d = acc_cnt_q;
      if (accept) begin
        if (ivl_len < min_ivl_q) min_ivl_d = ivl_len;
        acc_cnt_d = acc_cnt_q + 8'd1;
        o_done    = (acc_cnt_q == ACC_LAST);
      end
    end
    if ((i_wait || i_meas) && !i_edge) begin
      if (to_cnt_q == TO_LAST) o_timeout = 1'b1;
      else                     to_cnt_d  = to_cnt_q + 8'd1;
    end
  end

  // On the final accepted edge this already includes that edge's interval.
  assign o_min_ivl = min_ivl_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ivl_cnt_q <= '0;
      min_ivl_q <= '1;
      acc_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      ivl_cnt_q <= ivl_cnt_d;
      min_ivl_q <= min_ivl_d;
      acc_cnt_q <= acc_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// CDR bring-up sequencer: measure nb_P, run counter_decision, phase-check edges, lock / loss-of-lock.
// Outputs registered, one cycle after the deciding input; no backpressure. CDR_LOCK_CTRL_STATS_EN adds the loss counter.
module cdr_lock_ctrl
  import cdr_pkg::*;
#(
  parameter int NBP_W      = NBP_W_DEF,
  parameter int NBP_MIN    = 4,
  parameter int MEAS_EDGES = 8,
  parameter int TIMEOUT    = 63,
  parameter int PH_TOL     = 2,
  parameter int LOCK_CNT   = 16,
  parameter int MISS_MAX   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_edge,
  input  logic             i_dec,
  output logic             o_cdr_run,
  output logic [NBP_W-1:0] o_nb_p,
  output logic             o_locked,
  output logic             o_err,
  output logic [2:0]       o_state,
  output logic [7:0]       o_loss_cnt
);

  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0]       MISS_LAST = 8'(MISS_MAX - 1);
  localparam logic [NBP_W-1:0] TOL       = PH_TOL[NBP_W-1:0];

  cdr_state_e       state_q, state_d;
  logic             run_q, run_d, locked_q, locked_d, err_q, err_d, loss_q, loss_d;
  logic [NBP_W-1:0] nb_p_q, nb_p_d, ph_cnt_q, ph_cnt_d, ph_next, phase, half, ph_diff, meas_min;
  logic [7:0]       good_cnt_q, good_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [1:0]       dec_cnt_q, dec_cnt_d;
  logic             meas_done, meas_timeout, edge_good, miss_hit;

  cdr_interval_meas #(
    .NBP_W(NBP_W), .NBP_MIN(NBP_MIN), .MEAS_EDGES(MEAS_EDGES), .TIMEOUT(TIMEOUT)
  ) u_meas (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wait    (state_q == WAIT_EDGE),
    .i_meas    (state_q == MEASURE),
    .i_edge    (i_edge),
    .o_done    (meas_done),
    .o_timeout (meas_timeout),
    .o_min_ivl (meas_min)
  );

  // An edge landing on the decision strobe has phase 0 and is always bad.
  always_comb begin
    ph_next   = (ph_cnt_q == '1) ? ph_cnt_q : ph_cnt_q + 1'b1;
    phase     = i_dec ? '0 : ph_cnt_q;
    half      = nb_p_q >> 1;
    ph_diff   = (phase >= half) ? phase - half : half - phase;
    edge_good = !i_dec && (ph_diff <= TOL);
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    nb_p_d     = nb_p_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    loss_d     = 1'b0;
    ph_cnt_d   = '0;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    miss_hit   = 1'b0;
    // Loss of lock clears counter_decision for a single cycle, then lets it run on the held nb_P.
    if (loss_q) run_d = 1'b1;
    if (i_stop) begin
      state_d    = IDLE;
      run_d      = 1'b0;
      locked_d   = 1'b0;
      good_cnt_d = '0;
      miss_cnt_d = '0;
      dec_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          run_d = 1'b0;
          if (i_start) state_d = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (i_edge)            state_d = MEASURE;
          else if (meas_timeout) err_d   = 1'b1;
        end
        MEASURE: begin
          if (meas_done) begin
            nb_p_d     = meas_min;
            run_d      = 1'b1;
            good_cnt_d = '0;
            state_d    = TRACK;
          end else if (meas_timeout) begin
            err_d   = 1'b1;
            state_d = WAIT_EDGE;
          end
        end
        TRACK: begin
          ph_cnt_d = i_dec ? '0 : ph_next;
          if (i_edge) begin
            if (!edge_good) begin
              good_cnt_d = '0;
            end else if (good_cnt_q == LOCK_LAST) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              good_cnt_d = '0;
              miss_cnt_d = '0;
              dec_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 8'd1;
            end
          end
        end
        LOCKED: begin
          ph_cnt_d = i_dec ? '0 : ph_next;
          if (i_edge) begin
            dec_cnt_d = '0;
            if (edge_good) miss_cnt_d = '0;
            else           miss_hit   = 1'b1;
          end else if (i_dec) begin
            if (dec_cnt_q == 2'd2) begin
              dec_cnt_d = '0;
              miss_hit  = 1'b1;
            end else begin
              dec_cnt_d = dec_cnt_q + 2'd1;
            end
          end
          if (miss_hit) begin
            if (miss_cnt_q == MISS_LAST) begin
              state_d    = WAIT_EDGE;
              locked_d   = 1'b0;
              err_d      = 1'b1;
              run_d      = 1'b0;
              loss_d     = 1'b1;
              ph_cnt_d   = '0;
              miss_cnt_d = '0;
              dec_cnt_d  = '0;
              good_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      nb_p_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      loss_q     <= 1'b0;
      ph_cnt_q   <= '0;
      good_cnt_q <= '0;
      miss_cnt_q <= '0;
      dec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      nb_p_q     <= nb_p_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      loss_q     <= loss_d;
      ph_cnt_q   <= ph_cnt_d;
      good_cnt_q <= good_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
    end
  end

`ifdef CDR_LOCK_CTRL_STATS_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb loss_cnt_d = loss_d ? sat_inc(loss_cnt_q, 8'd255) : loss_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) loss_cnt_q <= '0;
    else       loss_cnt_q <= loss_cnt_d;
  end

  assign o_loss_cnt = loss_cnt_q;
`else
  assign o_loss_cnt = '0;
`endif

  assign o_cdr_run = run_q;
  assign o_nb_p    = nb_p_q;
  assign o_locked  = locked_q;
  assign o_err     = err_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Directed bench for cdr_lock_ctrl with a queue of expected results popped when the DUT produces them.
module tb_cdr_lock_ctrl;
  import cdr_pkg::*;

  logic       i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_stop = 1'b0, i_edge = 1'b0, i_dec = 1'b0;
  logic       o_cdr_run, o_locked, o_err;
  logic [5:0] o_nb_p;
  logic [2:0] o_state;
  logic [7:0] o_loss_cnt;

  int          checks = 0, failures = 0;
  int unsigned exp_q[$];
  int          good_run;
  // Edge position within a 16-cycle symbol; phase seen by the DUT is position-1.
  int          pos_tab [27] = '{9, 7, 11, 10, 8, 9, 8, 10, 7, 9, 4,
                                 9, 11, 7, 8, 10, 9, 9, 8, 7, 11, 10, 9, 8, 9, 10, 9};
  int          ivl_tab [9]  = '{32, 16, 48, 16, 2, 30, 16, 32, 16};

  cdr_lock_ctrl dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_edge     (i_edge),
    .i_dec      (i_dec),
    .o_cdr_run  (o_cdr_run),
    .o_nb_p     (o_nb_p),
    .o_locked   (o_locked),
    .o_err      (o_err),
    .o_state    (o_state),
    .o_loss_cnt (o_loss_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: observed=%0d expected=<nothing queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic cyc(input logic dec, input logic edg);
    i_dec  = dec;
    i_edge = edg;
    @(posedge i_clk);
    #1;
    i_dec  = 1'b0;
    i_edge = 1'b0;
  endtask

  task automatic edge_after(input int n);
    repeat (n - 1) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
  endtask

  task automatic sym(input int pos);
    for (int c = 0; c < 16; c++) cyc(c == 0, (pos != 0) && (c == pos));
  endtask

  task automatic acquire();
    cyc(1'b0, 1'b1);
    repeat (8) edge_after(16);
  endtask

  task automatic lock_up();
    repeat (16) sym(9);
  endtask

  task automatic wait_err(input string tag, input int limit);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      cyc(1'b0, 1'b0);
      n++;
      seen = o_err;
    end
    sb_check(tag, seen ? n : 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, o_state, IDLE);
    check({tag, "_run"}, o_cdr_run, 0);
    check({tag, "_nbp"}, o_nb_p, 0);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_loss"}, o_loss_cnt, 0);
  endtask

  function automatic bit good_phase(input int pos);
    int ph;
    ph = pos - 1;
    return (ph >= 6) && (ph <= 10);
  endfunction

  initial begin
    repeat (3) cyc(1'b0, 1'b0);
    i_rst = 1'b0;
    check_reset("rst");

    // Regular 16-cycle preamble
    i_start = 1'b1; cyc(1'b0, 1'b0); i_start = 1'b0;
    check("start_state", o_state, WAIT_EDGE);
    cyc(1'b0, 1'b1);
    check("meas_state", o_state, MEASURE);
    exp_q.push_back(16);
    repeat (7) edge_after(16);
    check("run_pre", o_cdr_run, 0);
    edge_after(16);
    check("trk_state", o_state, TRACK);
    check("trk_run", o_cdr_run, 1);
    sb_check("nbp_reg", o_nb_p);
    check("trk_locked", o_locked, 0);

    // Phase tracking with jitter and one bad edge
    good_run = 0;
    foreach (pos_tab[i]) begin
      sym(pos_tab[i]);
      good_run = good_phase(pos_tab[i]) ? good_run + 1 : 0;
      check("lock_prog", o_locked, good_run >= 16);
    end
    check("lock_state", o_state, LOCKED);

    // Edges stop: loss on the 12th strobe
    repeat (11) sym(0);
    check("pre_loss_lock", o_locked, 1);
    check("pre_loss_err", o_err, 0);
    cyc(1'b1, 1'b0);
    check("loss_locked", o_locked, 0);
    check("loss_err", o_err, 1);
    check("loss_run", o_cdr_run, 0);
    check("loss_state", o_state, WAIT_EDGE);
    cyc(1'b0, 1'b0);
    check("loss_err_clr", o_err, 0);
    check("loss_run_back", o_cdr_run, 1);
    check("loss_nbp_hold", o_nb_p, 16);

    // Stop, then WAIT_EDGE timeout
    i_stop = 1'b1; cyc(1'b0, 1'b0); i_stop = 1'b0;
    check("stop_state", o_state, IDLE);
    check("stop_run", o_cdr_run, 0);
    check("stop_nbp", o_nb_p, 16);
    i_start = 1'b1; cyc(1'b0, 1'b0); i_start = 1'b0;
    exp_q.push_back(63);
    wait_err("to_wait_cyc", 100);
    check("to_wait_state", o_state, WAIT_EDGE);
    cyc(1'b0, 1'b0);
    check("to_err_pulse", o_err, 0);
    cyc(1'b0, 1'b1);
    edge_after(16);
    edge_after(16);
    i_stop = 1'b1; cyc(1'b0, 1'b0); i_stop = 1'b0;
    check("stop_meas_state", o_state, IDLE);
    check("stop_meas_run", o_cdr_run, 0);

    // MEASURE timeout discards a short minimum; then glitch rejection
    i_start = 1'b1; cyc(1'b0, 1'b0); i_start = 1'b0;
    cyc(1'b0, 1'b1);
    edge_after(8);
    exp_q.push_back(63);
    wait_err("to_meas_cyc", 100);
    check("to_meas_state", o_state, WAIT_EDGE);
    cyc(1'b0, 1'b1);
    exp_q.push_back(16);
    for (int i = 0; i < 8; i++) edge_after(ivl_tab[i]);
    check("glitch_not_cnt", o_state, MEASURE);
    edge_after(ivl_tab[8]);
    check("glitch_trk", o_state, TRACK);
    sb_check("glitch_nbp", o_nb_p);

    // Loss by bad edges, then loss by silence
    lock_up();
    check("lock2", o_locked, 1);
    repeat (3) sym(4);
    check("bad3_locked", o_locked, 1);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("bad_loss_err", o_err, 1);
    check("bad_loss_state", o_state, WAIT_EDGE);
    cyc(1'b0, 1'b0);
    exp_q.push_back(16);
    acquire();
    sb_check("reacq_nbp", o_nb_p);
    lock_up();
    repeat (11) sym(0);
    cyc(1'b1, 1'b0);
    check("loss3_err", o_err, 1);
`ifdef CDR_LOCK_CTRL_STATS_EN
    exp_q.push_back(3);
`else
    exp_q.push_back(0);
`endif
    sb_check("loss_cnt", o_loss_cnt);

    // Reset while locked
    exp_q.push_back(16);
    acquire();
    sb_check("reacq2_nbp", o_nb_p);
    lock_up();
    check("lock4_state", o_state, LOCKED);
    i_rst = 1'b1; cyc(1'b0, 1'b0); i_rst = 1'b0;
    check_reset("rst_lk");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
